// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the engine-to-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default widths, transfer typedef, core-ID typedef, round-robin helper.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 48;
  localparam int DATA_W_DEF = 64;
  localparam int CID_W_DEF  = 2;

  typedef logic [CID_W_DEF-1:0] cid_t;

  // One downstream transfer at the default widths, independent of opcode.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } xfer_t;

  // Pointer value that follows a grant to core k among n cores.
  function automatic int rr_next(input int k, input int n);
    return (k + 1 == n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Core-ID tag FIFO recording the issuer of every outstanding read, in issue order.
// Latency: push visible at head/empty on the next cycle; head is a combinational read.
// Backpressure: full/empty are exported; push when full and pop when empty are ignored.
// Ports: clk, rst_n, push/push_dat, pop, head_dat, full, empty.
module mem_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CORES engines onto one memory port, with read-data return steering.
// Latency: grant and downstream request are combinational; read data reaches the core 1 cycle after mem_rvalid.
// Backpressure: no grant while mem_ready=0; reads also wait while the tag FIFO is full, writes do not.
// Ports: core_* initiator side (req/we/addr/wdata in, gnt/valid/rdata out), mem_* downstream, err_orphan sticky.
// Optional: MEM_ARBITER_STATS_EN adds stat_grants (per-core, saturating) and stat_stall counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int CID_W     = CID_W_DEF,
  parameter int TAG_DEPTH = 8,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_valid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        err_orphan
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [NUM_CORES*32-1:0]     stat_grants,
  output logic [31:0]                 stat_stall
`endif
);

  logic [CID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] core_valid_q, core_valid_d;
  logic [DATA_W-1:0]    core_rdata_q, core_rdata_d;
  logic                 err_orphan_q, err_orphan_d;

  logic [NUM_CORES-1:0] elig;
  logic                 gnt_any;
  logic [CID_W-1:0]     win_cid;
  logic                 tag_push, tag_pop;
  logic                 fifo_full, fifo_empty;
  logic [CID_W-1:0]     head_cid;

  // Full is sampled before any same-cycle pop, so a full FIFO always stalls reads.
  always_comb begin
    int idx;
    elig     = '0;
    core_gnt = '0;
    gnt_any  = 1'b0;
    win_cid  = '0;
    idx      = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      elig[i] = core_req[i] && mem_ready && (core_we[i] || !fifo_full);
    end
    for (int off = 0; off < NUM_CORES; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        win_cid = CID_W'(idx);
      end
    end
    if (gnt_any) core_gnt[win_cid] = 1'b1;
  end

  always_comb begin
    mem_req   = gnt_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any) begin
      mem_we    = core_we[win_cid];
      mem_addr  = core_addr[int'(win_cid)*ADDR_W +: ADDR_W];
      mem_wdata = core_wdata[int'(win_cid)*DATA_W +: DATA_W];
    end
  end

  assign tag_push = gnt_any && !core_we[win_cid];
  // A response with nothing outstanding is an orphan: it moves no pointer.
  assign tag_pop  = mem_rvalid && !fifo_empty;

  mem_arb_tag_fifo #(
    .WIDTH (CID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_dat (win_cid),
    .pop      (tag_pop),
    .head_dat (head_cid),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    rr_ptr_d     = gnt_any ? CID_W'(rr_next(int'(win_cid), NUM_CORES)) : rr_ptr_q;
    core_valid_d = '0;
    core_rdata_d = core_rdata_q;
    err_orphan_d = err_orphan_q | (mem_rvalid && fifo_empty);
    if (tag_pop) begin
      core_valid_d[head_cid] = 1'b1;
      core_rdata_d           = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      core_valid_q <= '0;
      core_rdata_q <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      core_valid_q <= core_valid_d;
      core_rdata_q <= core_rdata_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign core_valid = core_valid_q;
  assign core_rdata = core_rdata_q;
  assign err_orphan = err_orphan_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [NUM_CORES-1:0][31:0] grants_q, grants_d;
  logic [31:0]                stall_q, stall_d;

  always_comb begin
    grants_d = grants_q;
    stall_d  = stall_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_gnt[i] && (grants_q[i] != '1)) grants_d[i] = grants_q[i] + 32'd1;
    end
    if ((|core_req) && !gnt_any && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      grants_q <= grants_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_grants = grants_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a queue-based behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int TD = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    core_req, core_we;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_gnt, core_valid;
  logic [DW-1:0]   core_rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready, mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            err_orphan;
`ifdef MEM_ARBITER_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_stall;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CORES(N), .CID_W(2), .TAG_DEPTH(TD), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_valid (core_valid),
    .core_rdata (core_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err_orphan (err_orphan)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall (stat_stall)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural model: pointer as an integer, outstanding reads as a queue of core IDs.
  int           m_rr;
  int           m_tags[$];
  logic [N-1:0] m_valid;
  logic [DW-1:0] m_rdata;
  logic         m_orphan;

  // Downstream memory model: fixed latency, in-order responses.
  bit mem_auto;
  int mem_lat;
  typedef struct { int due; logic [DW-1:0] data; } resp_t;
  resp_t pend[$];

  typedef struct { int core; logic [AW-1:0] a; int c; } iss_t;
  iss_t sb[$];

  int            exp_w;
  logic [N-1:0]  gnt_exp;
  logic          req_exp, we_exp;
  logic [AW-1:0] addr_exp;
  logic [DW-1:0] wdata_exp;

  function automatic int exp_winner();
    for (int off = 0; off < N; off++) begin
      int i;
      i = (m_rr + off) % N;
      if (core_req[i] && mem_ready && (core_we[i] || m_tags.size() < TD)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0;
    m_tags.delete();
    m_valid  = '0;
    m_rdata  = '0;
    m_orphan = 1'b0;
    pend.delete();
    sb.delete();
  endtask

  task automatic rand_core(input int i);
    logic [63:0] r;
    r = {$urandom, $urandom};
    core_addr[i*AW +: AW] = r[AW-1:0];
    core_wdata[i*DW +: DW] = {$urandom, $urandom};
  endtask

  // Inputs for this cycle are in place; drive memory side and compute expected outputs.
  task automatic settle();
    if (mem_auto) begin
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend[0].data;
        pend.delete(0);
      end
    end
    #1;
    exp_w     = exp_winner();
    gnt_exp   = '0;
    req_exp   = 1'b0;
    we_exp    = 1'b0;
    addr_exp  = '0;
    wdata_exp = '0;
    if (exp_w >= 0) begin
      gnt_exp[exp_w] = 1'b1;
      req_exp   = 1'b1;
      we_exp    = core_we[exp_w];
      addr_exp  = core_addr[exp_w*AW +: AW];
      wdata_exp = core_wdata[exp_w*DW +: DW];
    end
  endtask

  // Apply the clock edge to the model, then to the DUT.
  task automatic advance();
    resp_t r;
    m_valid = '0;
    if (mem_rvalid) begin
      if (m_tags.size() == 0) begin
        m_orphan = 1'b1;
      end else begin
        m_valid[m_tags[0]] = 1'b1;
        m_rdata = mem_rdata;
        m_tags.delete(0);
      end
    end
    if (exp_w >= 0) begin
      if (!core_we[exp_w]) begin
        m_tags.push_back(exp_w);
        if (mem_auto) begin
          r.due  = cyc + mem_lat;
          r.data = {16'hA5A5, core_addr[exp_w*AW +: AW]};
          pend.push_back(r);
        end
      end
      m_rr = (exp_w + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    mem_auto = 1'b1; mem_lat = 3;
    model_reset();
    #23;
    checks++;
    if ({core_gnt, mem_req, core_valid, core_rdata, err_orphan, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_state gnt=%b req=%b valid=%b rdata=%h orphan=%b, required all zero",
               core_gnt, mem_req, core_valid, core_rdata, err_orphan);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    settle();
    checks++;
    if ({core_gnt, mem_req} !== {gnt_exp, req_exp}) begin
      errors++;
      $display("FAIL idle_after_reset gnt=%b req=%b, required gnt=%b req=%b", core_gnt, mem_req, gnt_exp, req_exp);
    end
    advance();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rr_exp;
    int g;
    iss_t e;
    mem_auto = 1'b1; mem_lat = 3; mem_ready = 1'b1;
    core_we = '0; core_req = '1;
    for (int i = 0; i < N; i++) rand_core(i);
    for (int t = 0; t < 24; t++) begin
      if (t == 16) core_req = '0;
      settle();
      checks++;
      if ({core_gnt, mem_req, mem_we & mem_req, mem_addr, mem_wdata} !== {gnt_exp, req_exp, we_exp, addr_exp, wdata_exp}) begin
        errors++;
        $display("FAIL rr_grant_path cyc=%0d gnt=%b addr=%h, required gnt=%b addr=%h", cyc, core_gnt, mem_addr, gnt_exp, addr_exp);
      end
      checks++;
      if ({core_valid, core_rdata, err_orphan} !== {m_valid, m_rdata, m_orphan}) begin
        errors++;
        $display("FAIL rr_return cyc=%0d valid=%b rdata=%h, required valid=%b rdata=%h", cyc, core_valid, core_rdata, m_valid, m_rdata);
      end
      if (t < 16) begin
        rr_exp = 4'b0001 << (t % N);
        checks++;
        if (core_gnt !== rr_exp) begin
          errors++;
          $display("FAIL rr_order t=%0d gnt=%b, required %b", t, core_gnt, rr_exp);
        end
      end
      if (|core_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rr_own_data unexpected valid=%b, required no response", core_valid);
        end else begin
          e = sb[0];
          sb.delete(0);
          if (core_valid !== (4'b0001 << e.core) || core_rdata !== {16'hA5A5, e.a} || cyc != e.c + 4) begin
            errors++;
            $display("FAIL rr_own_data cyc=%0d valid=%b rdata=%h, required valid core %0d rdata=%h at cyc %0d",
                     cyc, core_valid, core_rdata, e.core, {16'hA5A5, e.a}, e.c + 4);
          end
        end
      end
      g = exp_w;
      if (g >= 0) begin
        e.core = g; e.a = core_addr[g*AW +: AW]; e.c = cyc;
        sb.push_back(e);
      end
      advance();
      if (g >= 0) rand_core(g);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rr_all_returned left=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    mem_auto = 1'b1; mem_lat = 2;
    core_req = 4'b0100; core_we = '0; mem_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (t == 5) mem_ready = 1'b1;
      settle();
      checks++;
      if ({core_gnt, mem_req} !== {gnt_exp, req_exp}) begin
        errors++;
        $display("FAIL bp_model t=%0d gnt=%b req=%b, required gnt=%b req=%b", t, core_gnt, mem_req, gnt_exp, req_exp);
      end
      checks++;
      if (t < 5 && {core_gnt, mem_req} !== 5'b0) begin
        errors++;
        $display("FAIL bp_hold t=%0d gnt=%b req=%b, required 0", t, core_gnt, mem_req);
      end else if (t == 5 && core_gnt !== 4'b0100) begin
        errors++;
        $display("FAIL bp_first_grant gnt=%b, required 0100", core_gnt);
      end
      advance();
    end
    core_req = '0;
    for (int t = 0; t < 5; t++) begin
      settle();
      checks++;
      if ({core_valid, core_rdata, err_orphan} !== {m_valid, m_rdata, m_orphan}) begin
        errors++;
        $display("FAIL bp_return t=%0d valid=%b rdata=%h, required valid=%b rdata=%h", t, core_valid, core_rdata, m_valid, m_rdata);
      end
      advance();
    end
  endtask

  task automatic test_full_fifo();
    int g;
    mem_auto = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1;
    core_req = 4'b1101; core_we = '0;
    for (int t = 0; t < 20 && m_tags.size() < TD; t++) begin
      settle();
      checks++;
      if ({core_gnt, mem_req, mem_addr} !== {gnt_exp, req_exp, addr_exp}) begin
        errors++;
        $display("FAIL fill_grant t=%0d gnt=%b addr=%h, required gnt=%b addr=%h", t, core_gnt, mem_addr, gnt_exp, addr_exp);
      end
      g = exp_w;
      advance();
      if (g >= 0) rand_core(g);
    end
    settle();
    checks++;
    if (core_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL full_blocks_read gnt=%b, required 0000", core_gnt);
    end
    advance();
    core_req = 4'b1111; core_we = 4'b0010;
    settle();
    checks++;
    if ({core_gnt, mem_we, mem_addr} !== {4'b0010, 1'b1, core_addr[1*AW +: AW]}) begin
      errors++;
      $display("FAIL full_write_passes gnt=%b we=%b, required gnt=0010 we=1", core_gnt, mem_we);
    end
    advance();
    core_req = 4'b1101; core_we = '0; mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
    settle();
    checks++;
    if (core_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL full_pop_same_cycle gnt=%b, required 0000", core_gnt);
    end
    advance();
    mem_rvalid = 1'b0;
    settle();
    checks++;
    if (core_gnt !== gnt_exp || core_gnt === 4'b0000) begin
      errors++;
      $display("FAIL read_after_pop gnt=%b, required %b", core_gnt, gnt_exp);
    end
    checks++;
    if ({core_valid, core_rdata} !== {m_valid, m_rdata}) begin
      errors++;
      $display("FAIL full_pop_return valid=%b rdata=%h, required valid=%b rdata=%h", core_valid, core_rdata, m_valid, m_rdata);
    end
    g = exp_w;
    advance();
    if (g >= 0) rand_core(g);
    core_req = '0;
    for (int t = 0; t < TD + 1; t++) begin
      mem_rvalid = (t < TD); mem_rdata = {$urandom, $urandom};
      settle();
      checks++;
      if ({core_valid, core_rdata, err_orphan} !== {m_valid, m_rdata, m_orphan}) begin
        errors++;
        $display("FAIL drain_return t=%0d valid=%b rdata=%h, required valid=%b rdata=%h", t, core_valid, core_rdata, m_valid, m_rdata);
      end
      advance();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_routing();
    logic [N-1:0]  seq_core [3];
    logic [DW-1:0] seq_data [3];
    seq_core[0] = 4'b1000; seq_core[1] = 4'b0001; seq_core[2] = 4'b1000;
    seq_data[0] = 64'hA;   seq_data[1] = 64'hB;   seq_data[2] = 64'hC;
    mem_auto = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1; core_we = '0;
    for (int k = 0; k < 3; k++) begin
      core_req = seq_core[k];
      settle();
      checks++;
      if (core_gnt !== seq_core[k]) begin
        errors++;
        $display("FAIL route_issue k=%0d gnt=%b, required %b", k, core_gnt, seq_core[k]);
      end
      advance();
    end
    core_req = '0;
    for (int k = 0; k < 5; k++) begin
      mem_rvalid = (k < 3);
      mem_rdata  = (k < 3) ? seq_data[k] : {$urandom, $urandom};
      settle();
      if (k > 0 && k < 4) begin
        checks++;
        if ({core_valid, core_rdata} !== {seq_core[k-1], seq_data[k-1]}) begin
          errors++;
          $display("FAIL route_return k=%0d valid=%b rdata=%h, required valid=%b rdata=%h",
                   k, core_valid, core_rdata, seq_core[k-1], seq_data[k-1]);
        end
      end
      checks++;
      if ({core_valid, core_rdata, err_orphan} !== {m_valid, m_rdata, m_orphan}) begin
        errors++;
        $display("FAIL route_model k=%0d valid=%b rdata=%h, required valid=%b rdata=%h", k, core_valid, core_rdata, m_valid, m_rdata);
      end
      advance();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_orphan();
    logic [DW-1:0] held;
    mem_auto = 1'b0; core_req = '0;
    held = core_rdata;
    for (int t = 0; t < 5; t++) begin
      mem_rvalid = (t == 0); mem_rdata = {$urandom, $urandom};
      settle();
      if (t > 0) begin
        checks++;
        if ({err_orphan, core_valid, core_rdata} !== {1'b1, 4'b0000, held}) begin
          errors++;
          $display("FAIL orphan_sticky t=%0d orphan=%b valid=%b rdata=%h, required orphan=1 valid=0000 rdata=%h",
                   t, err_orphan, core_valid, core_rdata, held);
        end
      end
      checks++;
      if ({core_valid, core_rdata, err_orphan} !== {m_valid, m_rdata, m_orphan}) begin
        errors++;
        $display("FAIL orphan_model t=%0d valid=%b orphan=%b, required valid=%b orphan=%b", t, core_valid, err_orphan, m_valid, m_orphan);
      end
      advance();
    end
    mem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL orphan_reset orphan=%b, required 0", err_orphan);
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midburst();
    int g;
    mem_auto = 1'b1; mem_lat = 2; mem_ready = 1'b1; core_we = '0;
    core_req = 4'b0010;
    for (int t = 0; t < 5; t++) begin
      if (t == 1) core_req = '0;
      settle();
      checks++;
      if ({core_gnt, core_valid, core_rdata} !== {gnt_exp, m_valid, m_rdata}) begin
        errors++;
        $display("FAIL mid_warmup t=%0d gnt=%b valid=%b rdata=%h, required gnt=%b valid=%b rdata=%h",
                 t, core_gnt, core_valid, core_rdata, gnt_exp, m_valid, m_rdata);
      end
      advance();
    end
    mem_lat = 20; core_req = '1;
    for (int t = 0; t < 4; t++) begin
      settle();
      checks++;
      if (core_gnt !== gnt_exp) begin
        errors++;
        $display("FAIL mid_burst t=%0d gnt=%b, required %b", t, core_gnt, gnt_exp);
      end
      g = exp_w;
      advance();
      if (g >= 0) rand_core(g);
    end
    core_req = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({core_gnt, mem_req, core_valid, core_rdata, err_orphan} !== '0) begin
      errors++;
      $display("FAIL mid_async_reset gnt=%b req=%b valid=%b rdata=%h orphan=%b, required all zero",
               core_gnt, mem_req, core_valid, core_rdata, err_orphan);
    end
    model_reset();
    mem_lat = 2;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    core_req = '1;
    for (int t = 0; t < 7; t++) begin
      if (t == 1) core_req = '0;
      settle();
      if (t == 0) begin
        checks++;
        if (core_gnt !== 4'b0001) begin
          errors++;
          $display("FAIL rr_after_reset gnt=%b, required 0001", core_gnt);
        end
      end
      checks++;
      if ({core_valid, core_rdata, err_orphan} !== {m_valid, m_rdata, m_orphan}) begin
        errors++;
        $display("FAIL post_reset_return t=%0d valid=%b rdata=%h orphan=%b, required valid=%b rdata=%h orphan=%b",
                 t, core_valid, core_rdata, err_orphan, m_valid, m_rdata, m_orphan);
      end
      advance();
    end
  endtask

  task automatic test_random();
    int g;
    mem_auto = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      mem_lat = (ph == 0) ? 2 : 12;
      for (int t = 0; t < 170; t++) begin
        if (t < 150) begin
          core_req  = N'($urandom);
          core_we   = N'($urandom);
          mem_ready = ($urandom % 4) != 0;
          for (int i = 0; i < N; i++) rand_core(i);
        end else begin
          core_req = '0;
        end
        settle();
        checks++;
        if ({core_gnt, mem_req, mem_we & mem_req, mem_addr, mem_wdata} !== {gnt_exp, req_exp, we_exp, addr_exp, wdata_exp}) begin
          errors++;
          $display("FAIL rand_grant_path cyc=%0d gnt=%b we=%b addr=%h, required gnt=%b we=%b addr=%h",
                   cyc, core_gnt, mem_we, mem_addr, gnt_exp, we_exp, addr_exp);
        end
        checks++;
        if ({core_valid, core_rdata, err_orphan} !== {m_valid, m_rdata, m_orphan}) begin
          errors++;
          $display("FAIL rand_return cyc=%0d valid=%b rdata=%h orphan=%b, required valid=%b rdata=%h orphan=%b",
                   cyc, core_valid, core_rdata, err_orphan, m_valid, m_rdata, m_orphan);
        end
        g = exp_w;
        advance();
      end
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_full_fifo();
    test_routing();
    test_orphan();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
